// File: rtl/golay24_dec_cand_select_pkg.sv
// Shared types and constants for the Golay(24,12) candidate-selection stage.
// The metric width grows from the per-bit LLR width by the bits needed to sum 24 magnitudes.
package golay24_dec_cand_select_pkg;

    localparam int cDAT_W         = 24;
    localparam int cMETRIC_GROWTH = 5;
    localparam int cERR_W         = 5;

    typedef logic [cDAT_W-1:0] dat_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } cand_state_t;

    // Bit count of a 24-bit word; result fits in 5 bits (0..24).
    function automatic logic [cERR_W-1:0] popcnt24(input dat_t dat);
        logic [cERR_W-1:0] sum;
        sum = 5'd0;
        for (int i = 0; i < cDAT_W; i++) begin
            sum = sum + {4'd0, dat[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/golay24_dec_popcnt24.sv
// Registered 24-bit population count; shared with the metric calculator.
module golay24_dec_popcnt24
    import golay24_dec_cand_select_pkg::*;
(
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iclkena,
    input  dat_t              idat,
    output logic [cERR_W-1:0] ocnt
);

    // Count register.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            ocnt <= 5'd0;
        end else if (iclkena) begin
            ocnt <= popcnt24(idat);
        end
    end

endmodule

// File: rtl/golay24_dec_cand_select.sv
// Picks the minimum-metric candidate of each frame and emits the decoded word
// with its metric, bit-error count against the channel decision and a decode-fail flag.
module golay24_dec_cand_select
    import golay24_dec_cand_select_pkg::*;
#(
    parameter int pLLR_W   = 4,
    parameter int pTAG_W   = 4,
    parameter int pIDX_NUM = 4
)
(
    input  logic                             iclk,
    input  logic                             ireset,
    input  logic                             iclkena,
    input  logic                             isop,
    input  logic                             ival,
    input  logic                             ieop,
    input  logic [pTAG_W-1:0]                itag,
    input  dat_t                             ich_hd,
    input  logic [pLLR_W+cMETRIC_GROWTH-1:0] ich_metric,
    input  dat_t                             icand_dat,
    input  logic [pLLR_W+cMETRIC_GROWTH-1:0] icand_metric,
    output logic                             oval,
    output logic [pTAG_W-1:0]                otag,
    output dat_t                             odat,
    output logic [pLLR_W+cMETRIC_GROWTH-1:0] ometric,
    output logic [cERR_W-1:0]                oerr,
    output logic                             odecfail
);

    localparam int cMETRIC_W = pLLR_W + cMETRIC_GROWTH;
    typedef logic [cMETRIC_W-1:0] metric_t;
    typedef logic [pTAG_W-1:0]    tag_t;
    typedef logic [pIDX_NUM:0]    cnt_t;

    localparam metric_t cMETRIC_FAIL = '1;
    localparam cnt_t    cCNT_ONE     = {{pIDX_NUM{1'b0}}, 1'b1};
    localparam cnt_t    cCNT_MAX     = {1'b1, {pIDX_NUM{1'b0}}};

    cand_state_t state_r, state_nxt_s;
    logic        start_s, acc_s, close_s, take_s;
    metric_t     fin_metric_s;
    dat_t        fin_dat_s;

    metric_t best_metric_r, chm_r;
    dat_t    best_dat_r, hd_r;
    tag_t    tag_r;
    cnt_t    cnt_r;

    logic    s1_val_r;
    metric_t s1_metric_r, s1_chm_r;
    dat_t    s1_dat_r, s1_hd_r;
    tag_t    s1_tag_r;
    logic    s1_fail_s;
    dat_t    s1_xor_s;

    // State register.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_r <= ST_IDLE;
        end else if (iclkena) begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: isop restarts from any state, a closing beat returns to idle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ival && isop && !ieop) begin
                    state_nxt_s = ST_ACC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACC: begin
                if (ival && ieop) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACC;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Beat decode and running-minimum selection; ties keep the earlier candidate.
    always_comb begin
        start_s = ival && isop;
        acc_s   = ival && !isop && (state_r == ST_ACC);
        close_s = ival && ieop && (isop || (state_r == ST_ACC));
        if (start_s) begin
            take_s = 1'b1;
        end else if (acc_s) begin
            take_s = (icand_metric < best_metric_r);
        end else begin
            take_s = 1'b0;
        end
        if (take_s) begin
            fin_metric_s = icand_metric;
            fin_dat_s    = icand_dat;
        end else begin
            fin_metric_s = best_metric_r;
            fin_dat_s    = best_dat_r;
        end
    end

    // Frame accumulator.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            best_metric_r <= '0;
            best_dat_r    <= '0;
            tag_r         <= '0;
            hd_r          <= '0;
            chm_r         <= '0;
            cnt_r         <= '0;
        end else if (iclkena) begin
            best_metric_r <= fin_metric_s;
            best_dat_r    <= fin_dat_s;
            if (start_s) begin
                tag_r <= itag;
                hd_r  <= ich_hd;
                chm_r <= ich_metric;
                cnt_r <= cCNT_ONE;
            end else if (acc_s && (cnt_r != cCNT_MAX)) begin
                cnt_r <= cnt_r + cCNT_ONE;
            end
        end
    end

    // Stage 1: capture the closed frame; a single-beat frame takes its fields straight from the inputs.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            s1_val_r    <= 1'b0;
            s1_metric_r <= '0;
            s1_dat_r    <= '0;
            s1_tag_r    <= '0;
            s1_hd_r     <= '0;
            s1_chm_r    <= '0;
        end else if (iclkena) begin
            s1_val_r <= close_s;
            if (close_s) begin
                s1_metric_r <= fin_metric_s;
                s1_dat_r    <= fin_dat_s;
                s1_tag_r    <= start_s ? itag       : tag_r;
                s1_hd_r     <= start_s ? ich_hd     : hd_r;
                s1_chm_r    <= start_s ? ich_metric : chm_r;
            end
        end
    end

    // A failed frame passes the channel decision through, so its error count must be zero.
    always_comb begin
        s1_fail_s = (s1_metric_r == cMETRIC_FAIL);
        if (s1_fail_s) begin
            s1_xor_s = '0;
        end else begin
            s1_xor_s = s1_dat_r ^ s1_hd_r;
        end
    end

    golay24_dec_popcnt24 u_popcnt (
        .iclk    (iclk),
        .ireset  (ireset),
        .iclkena (iclkena),
        .idat    (s1_xor_s),
        .ocnt    (oerr)
    );

    // Stage 2: output registers.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            oval     <= 1'b0;
            otag     <= '0;
            odat     <= '0;
            ometric  <= '0;
            odecfail <= 1'b0;
        end else if (iclkena) begin
            oval <= s1_val_r;
            if (s1_val_r) begin
                otag     <= s1_tag_r;
                odat     <= s1_fail_s ? s1_hd_r  : s1_dat_r;
                ometric  <= s1_fail_s ? s1_chm_r : s1_metric_r;
                odecfail <= s1_fail_s;
            end
        end
    end

endmodule

// File: tb/tb_golay24_dec_cand_select.sv
// Randomized and directed bench for golay24_dec_cand_select with a candidate-list reference model.
module tb_golay24_dec_cand_select;

    localparam logic [8:0] FAILM = 9'h1FF;

    logic        iclk = 1'b0;
    logic        ireset, iclkena, isop, ival, ieop;
    logic [3:0]  itag;
    logic [23:0] ich_hd, icand_dat;
    logic [8:0]  ich_metric, icand_metric;
    logic        oval, odecfail;
    logic [3:0]  otag;
    logic [23:0] odat;
    logic [8:0]  ometric;
    logic [4:0]  oerr;

    golay24_dec_cand_select dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena),
        .isop(isop), .ival(ival), .ieop(ieop), .itag(itag),
        .ich_hd(ich_hd), .ich_metric(ich_metric),
        .icand_dat(icand_dat), .icand_metric(icand_metric),
        .oval(oval), .otag(otag), .odat(odat), .ometric(ometric),
        .oerr(oerr), .odecfail(odecfail)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        int          due;
        logic [3:0]  tag;
        logic [23:0] dat;
        logic [8:0]  met;
        logic [4:0]  err;
        logic        fail;
    } res_t;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    res_t exp_q[$];
    res_t obs[$];

    // model frame state
    bit          in_frame = 1'b0;
    logic [8:0]  fm[$];
    logic [23:0] fd[$];
    logic [3:0]  m_tag;
    logic [23:0] m_hd;
    logic [8:0]  m_chm;

    // frame fields used by the driver
    logic [3:0]  f_tag;
    logic [23:0] f_hd;
    logic [8:0]  f_chm;
    logic [8:0]  mets[16];
    logic [23:0] dats[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic close_frame();
        res_t r;
        int   bi;
        bit   allf;
        bi = 0;
        allf = 1'b1;
        for (int k = 0; k < fm.size(); k++) begin
            if (fm[k] < fm[bi]) bi = k;
            if (fm[k] != FAILM) allf = 1'b0;
        end
        r.due  = en_cnt + 1;
        r.tag  = m_tag;
        r.fail = allf;
        r.dat  = allf ? m_hd : fd[bi];
        r.met  = allf ? m_chm : fm[bi];
        r.err  = allf ? 5'd0 : 5'($countones(fd[bi] ^ m_hd));
        exp_q.push_back(r);
        in_frame = 1'b0;
    endtask

    // Reference model and per-cycle output comparison.
    always @(posedge iclk) begin
        logic s_rst, s_ena, s_sop, s_val, s_eop;
        logic [3:0] s_tag;
        logic [23:0] s_hd, s_dat;
        logic [8:0] s_chm, s_met;
        res_t r, o;
        s_rst = ireset; s_ena = iclkena; s_sop = isop; s_val = ival; s_eop = ieop;
        s_tag = itag; s_hd = ich_hd; s_dat = icand_dat; s_chm = ich_metric; s_met = icand_metric;
        #1;
        if (s_rst) begin
            exp_q.delete();
            in_frame = 1'b0;
            chk("rst_oval", {31'd0, oval}, 32'd0);
            chk("rst_outs", {otag, odat, ometric, oerr, odecfail}, 32'd0);
            chk("rst_odat", {8'd0, odat}, 32'd0);
        end else if (s_ena) begin
            en_cnt++;
            if (s_val && s_sop) begin
                fm.delete(); fd.delete();
                fm.push_back(s_met); fd.push_back(s_dat);
                m_tag = s_tag; m_hd = s_hd; m_chm = s_chm;
                in_frame = 1'b1;
                if (s_eop) close_frame();
            end else if (s_val && in_frame) begin
                fm.push_back(s_met); fd.push_back(s_dat);
                if (s_eop) close_frame();
            end
            if (exp_q.size() > 0 && exp_q[0].due == en_cnt) begin
                r = exp_q.pop_front();
                chk("oval", {31'd0, oval}, 32'd1);
                chk("otag", {28'd0, otag}, {28'd0, r.tag});
                chk("odat", {8'd0, odat}, {8'd0, r.dat});
                chk("ometric", {23'd0, ometric}, {23'd0, r.met});
                chk("oerr", {27'd0, oerr}, {27'd0, r.err});
                chk("odecfail", {31'd0, odecfail}, {31'd0, r.fail});
            end else begin
                chk("oval_idle", {31'd0, oval}, 32'd0);
            end
            if (oval) begin
                o.due = en_cnt; o.tag = otag; o.dat = odat; o.met = ometric;
                o.err = oerr; o.fail = odecfail;
                obs.push_back(o);
            end
        end
    end

    task automatic drive(input logic rst, input logic ena, input logic sop, input logic val,
                         input logic eop, input logic [23:0] dat, input logic [8:0] met);
        @(negedge iclk);
        ireset = rst; iclkena = ena; isop = sop; ival = val; ieop = eop;
        itag = f_tag; ich_hd = f_hd; ich_metric = f_chm; icand_dat = dat; icand_metric = met;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 9'd0);
    endtask

    // n beats from mets/dats; optional stall (iclkena low 3 cycles) and a second isop
    task automatic send_frame(input int n, input int stall_at, input int sop2_at);
        for (int i = 0; i < n; i++) begin
            if (i == stall_at) begin
                for (int s = 0; s < 3; s++)
                    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 24'h5A5A5A, 9'd0);
            end
            drive(1'b0, 1'b1, (i == 0) || (i == sop2_at), 1'b1, i == n - 1, dats[i], mets[i]);
        end
    endtask

    initial begin
        int n0;
        res_t a, b;
        ireset = 1'b1; iclkena = 1'b1; isop = 1'b0; ival = 1'b0; ieop = 1'b0;
        itag = 4'd0; ich_hd = 24'd0; ich_metric = 9'd0; icand_dat = 24'd0; icand_metric = 9'd0;
        f_tag = 4'd0; f_hd = 24'd0; f_chm = 9'd0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 9'd0);
        idle(2);

        // basic selection
        for (int i = 0; i < 16; i++) begin
            mets[i] = 9'd12; dats[i] = 24'hFFF000 | 24'(i);
        end
        mets[0] = 9'd9; mets[1] = 9'd7; mets[2] = 9'd7; mets[3] = 9'd3; dats[3] = 24'h00000F;
        f_tag = 4'd5; f_hd = 24'h0000F0; f_chm = 9'd30;
        n0 = obs.size();
        send_frame(16, -1, -1);
        idle(4);
        chk("basic_count", obs.size() - n0, 32'd1);
        if (obs.size() > n0) begin
            chk("basic_met", {23'd0, obs[n0].met}, 32'd3);
            chk("basic_dat", {8'd0, obs[n0].dat}, 32'h00000F);
            chk("basic_tag", {28'd0, obs[n0].tag}, 32'd5);
            chk("basic_err", {27'd0, obs[n0].err}, 32'd8);
        end

        // tie keeps first; repeat with a stall mid-frame
        for (int i = 0; i < 16; i++) begin
            mets[i] = 9'd8; dats[i] = 24'h010101 * 24'(i + 1);
        end
        mets[2] = 9'd4; mets[6] = 9'd4;
        f_tag = 4'd9; f_hd = 24'h000000; f_chm = 9'd1;
        n0 = obs.size();
        send_frame(16, -1, -1);
        idle(4);
        send_frame(16, 7, -1);
        idle(4);
        chk("tie_count", obs.size() - n0, 32'd2);
        if (obs.size() > n0 + 1) begin
            a = obs[n0]; b = obs[n0 + 1];
            chk("tie_dat", {8'd0, a.dat}, 32'h030303);
            chk("tie_err", {27'd0, a.err}, 32'd6);
            chk("stall_same", {a.tag, a.dat, a.met}, {b.tag, b.dat, b.met});
            chk("stall_err", {27'd0, b.err}, {27'd0, a.err});
        end

        // decode fail
        for (int i = 0; i < 16; i++) begin
            mets[i] = FAILM; dats[i] = 24'h123456 + 24'(i);
        end
        f_tag = 4'd2; f_hd = 24'hABCDEF; f_chm = 9'd20;
        n0 = obs.size();
        send_frame(16, -1, -1);
        idle(4);
        chk("fail_count", obs.size() - n0, 32'd1);
        if (obs.size() > n0) begin
            chk("fail_flag", {31'd0, obs[n0].fail}, 32'd1);
            chk("fail_dat", {8'd0, obs[n0].dat}, 32'hABCDEF);
            chk("fail_met", {23'd0, obs[n0].met}, 32'd20);
            chk("fail_err", {27'd0, obs[n0].err}, 32'd0);
        end

        // back-to-back single-beat frames
        n0 = obs.size();
        for (int t = 1; t <= 3; t++) begin
            f_tag = 4'(t); f_hd = 24'h000001; f_chm = 9'd5;
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 24'h000003, 9'(t));
        end
        idle(4);
        chk("b2b_count", obs.size() - n0, 32'd3);
        if (obs.size() > n0 + 2) begin
            for (int t = 0; t < 3; t++) begin
                chk("b2b_tag", {28'd0, obs[n0 + t].tag}, 32'(t + 1));
                chk("b2b_cyc", obs[n0 + t].due - obs[n0].due, 32'(t));
            end
        end

        // isop again at beat 5: only the restarted frame is output
        for (int i = 0; i < 16; i++) begin
            mets[i] = 9'd50; dats[i] = 24'h00FF00 + 24'(i);
        end
        mets[1] = 9'd2; mets[9] = 9'd10;
        f_tag = 4'd7; f_hd = 24'h00FF00; f_chm = 9'd3;
        n0 = obs.size();
        send_frame(16, -1, 5);
        idle(4);
        chk("resop_count", obs.size() - n0, 32'd1);
        if (obs.size() > n0) begin
            chk("resop_met", {23'd0, obs[n0].met}, 32'd10);
            chk("resop_dat", {8'd0, obs[n0].dat}, 32'h00FF09);
        end

        // orphan beats in idle
        n0 = obs.size();
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b1, i == 3, 24'h111111, 9'd1);
        idle(4);
        chk("orphan_count", obs.size() - n0, 32'd0);

        // reset one clock after eop
        for (int i = 0; i < 4; i++) begin
            mets[i] = 9'(i + 1); dats[i] = 24'hC0FFEE;
        end
        f_tag = 4'd11; f_hd = 24'd0; f_chm = 9'd0;
        n0 = obs.size();
        send_frame(4, -1, -1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0, 9'd0);
        idle(4);
        chk("rst_count", obs.size() - n0, 32'd0);

        // random traffic
        for (int f = 0; f < 40; f++) begin
            int n;
            n = $urandom_range(1, 16);
            f_tag = 4'($urandom); f_hd = 24'($urandom); f_chm = 9'($urandom);
            for (int i = 0; i < n; i++) begin
                mets[i] = ($urandom_range(0, 3) == 0) ? FAILM : 9'($urandom_range(0, 40));
                dats[i] = 24'($urandom);
                if (f % 5 == 0) mets[i] = FAILM;
            end
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 4) == 0) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'($urandom), 9'd0);
                if ($urandom_range(0, 4) == 0) drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 24'($urandom), 9'd0);
                drive(1'b0, 1'b1, i == 0, 1'b1, i == n - 1, dats[i], mets[i]);
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        chk("drain", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
